// File: rtl/scan_seq_ctrl.sv
`default_nettype none
// =============================================================================
// scan_seq_ctrl : scan-chain load / capture / shift / unload sequencer.
// Optional MISR signature compactor enabled by macro SCAN_SEQ_MISR_EN.
// Revision: 1.0
// =============================================================================
module scan_seq_ctrl #(
  parameter int CHAIN_LEN = 19,
  parameter int CAP_CYC   = 1,
  parameter int CNT_W     = 5
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic [7:0]  NUM_PAT,
  input  logic        PAT_VALID,
  input  logic        PAT_DATA,
  output logic        PAT_READY,
  input  logic        SO,
  output logic        SI,
  output logic        SE,
  output logic        CHAIN_EN,
  output logic        RESP_VALID,
  output logic        RESP_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] SIGNATURE
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    SHIFT   = 3'd3,
    UNLOAD  = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [1:0]       LAST_CAP = 2'(CAP_CYC - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cap_cnt;
  logic [7:0]       pat_left;
  logic             busy_r;
  logic             done_r;
  logic             se_r;

  logic in_shift;
  logic step;
  logic last_step;
  logic cap_last;
  logic resp;
  logic start_ok;

  always_comb begin
    in_shift  = (state == LOAD) || (state == SHIFT);
    step      = (in_shift && PAT_VALID) || (state == UNLOAD);
    last_step = step && (cnt == LAST_CNT);
    cap_last  = (state == CAPTURE) && (cap_cnt == LAST_CAP);
    resp      = ((state == SHIFT) && PAT_VALID) || (state == UNLOAD);
    start_ok  = (state == IDLE) && START;

    nxt = state;
    case (state)
      IDLE:    if (START) nxt = (NUM_PAT == 8'd0) ? FIN : LOAD;
      LOAD:    if (last_step) nxt = CAPTURE;
      CAPTURE: if (cap_last) nxt = (pat_left > 8'd1) ? SHIFT : UNLOAD;
      SHIFT:   if (last_step) nxt = CAPTURE;
      UNLOAD:  if (last_step) nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // Abort wins over every other transition out of a busy state.
    if (ABORT && (state != IDLE)) nxt = IDLE;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_cnt  <= 2'd0;
      pat_left <= 8'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      se_r     <= 1'b0;
    end else begin
      state  <= nxt;
      busy_r <= (nxt == LOAD) || (nxt == CAPTURE) || (nxt == SHIFT) || (nxt == UNLOAD);
      done_r <= (nxt == FIN);
      se_r   <= (nxt == LOAD) || (nxt == SHIFT) || (nxt == UNLOAD);

      if (nxt != state)
        cnt <= '0;
      else if (step)
        cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;

      cap_cnt <= ((state == CAPTURE) && (nxt == CAPTURE)) ? cap_cnt + 2'd1 : 2'd0;

      if (start_ok)
        pat_left <= NUM_PAT;
      else if (cap_last && !ABORT)
        pat_left <= pat_left - 8'd1;
    end
  end

  // Handshake outputs follow PAT_VALID in the same cycle so a stall costs no bubble.
  always_comb begin
    PAT_READY  = !RST && in_shift && PAT_VALID;
    SI         = PAT_READY && PAT_DATA;
    SE         = !RST && se_r;
    CHAIN_EN   = !RST && (step || (state == CAPTURE));
    RESP_VALID = !RST && resp;
    RESP_DATA  = RESP_VALID && SO;
    BUSY       = !RST && busy_r;
    DONE       = !RST && done_r;
  end

`ifdef SCAN_SEQ_MISR_EN
  logic [15:0] misr;
  logic        fb;

  assign fb = misr[15] ^ SO;

  // Serial MISR, x^16 + x^12 + x^5 + 1, MSB-first feedback.
  always_ff @(posedge CK) begin
    if (RST)
      misr <= 16'h0000;
    else if (start_ok)
      misr <= 16'hFFFF;
    else if (resp)
      misr <= {misr[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end

  assign SIGNATURE = RST ? 16'h0000 : misr;
`else
  assign SIGNATURE = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scan_seq_ctrl.sv
`default_nettype none
// tb_scan_seq_ctrl : directed self-checking bench for scan_seq_ctrl (default parameters).
module tb_scan_seq_ctrl;

  logic        CK = 1'b0;
  logic        RST, START, ABORT, PAT_VALID, PAT_DATA, SO;
  logic [7:0]  NUM_PAT;
  logic        PAT_READY, SI, SE, CHAIN_EN, RESP_VALID, RESP_DATA, BUSY, DONE;
  logic [15:0] SIGNATURE;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-session observations
  int first_load, last_load, first_cap, n_cap, first_unl, last_unl;
  int done_cyc, n_done, n_resp, n_stall, n_se, n_chain, n_bad;
  logic busy_at1, busy_at_done;
  logic [15:0] sig_late;
  logic [23:0] vec_a, vec_b, vec_c;

  scan_seq_ctrl dut (
    .CK(CK), .RST(RST), .START(START), .ABORT(ABORT), .NUM_PAT(NUM_PAT),
    .PAT_VALID(PAT_VALID), .PAT_DATA(PAT_DATA), .PAT_READY(PAT_READY),
    .SO(SO), .SI(SI), .SE(SE), .CHAIN_EN(CHAIN_EN), .RESP_VALID(RESP_VALID),
    .RESP_DATA(RESP_DATA), .BUSY(BUSY), .DONE(DONE), .SIGNATURE(SIGNATURE)
  );

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [23:0] out_vec();
    return {PAT_READY, SI, SE, CHAIN_EN, RESP_VALID, RESP_DATA, BUSY, DONE, SIGNATURE};
  endfunction

  // Reference: 16'hFFFF shifted n times with a zero input bit, poly 0x1021.
  function automatic logic [15:0] misr_zero_ref(input int n);
    logic [15:0] m;
    m = 16'hFFFF;
    for (int i = 0; i < n; i++)
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000);
    return m;
  endfunction

  // Cycle 0 carries START; inputs change on negedge, outputs sampled 1ns later.
  task automatic run_session(input int np, input int st_from, input int st_len,
                             input int abort_at, input int rst_at, input bit so_zero,
                             input int max_cyc);
    first_load = -1; last_load = -1; first_cap = -1; n_cap = 0;
    first_unl = -1; last_unl = -1; done_cyc = -1; n_done = 0; n_resp = 0;
    n_stall = 0; n_se = 0; n_chain = 0; n_bad = 0; busy_at1 = 1'bx;
    busy_at_done = 1'bx; sig_late = 16'hxxxx; vec_a = 'x; vec_b = 'x; vec_c = 'x;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge CK);
      START     = (c == 0) || (c == rst_at);
      RST       = (c == rst_at);
      NUM_PAT   = np[7:0];
      PAT_VALID = !((c >= st_from) && (c < st_from + st_len));
      PAT_DATA  = 1'($urandom_range(0, 1));
      SO        = so_zero ? 1'b0 : 1'($urandom_range(0, 1));
      ABORT     = (c == abort_at);
      #1;
      if (PAT_READY && !RESP_VALID) begin
        if (first_load < 0) first_load = c;
        last_load = c;
      end
      if (CHAIN_EN && !SE) begin
        n_cap++;
        if (first_cap < 0) first_cap = c;
      end
      if (RESP_VALID && !PAT_READY) begin
        if (first_unl < 0) first_unl = c;
        last_unl = c;
      end
      if (RESP_VALID) n_resp++;
      if (SE && !CHAIN_EN) n_stall++;
      if (SE) n_se++;
      if (CHAIN_EN) n_chain++;
      if (RESP_VALID && !CHAIN_EN) n_bad++;
      if (PAT_READY && (SI !== PAT_DATA)) n_bad++;
      if (!PAT_READY && (SI !== 1'b0)) n_bad++;
      if (RESP_VALID && (RESP_DATA !== SO)) n_bad++;
      if (c == 1) busy_at1 = BUSY;
      if (c == abort_at + 1) vec_a = out_vec();
      if (c == rst_at) vec_a = out_vec();
      if (c == rst_at + 1) vec_b = out_vec();
      if (c == rst_at + 2) vec_c = out_vec();
      if (DONE) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc     = c;
          busy_at_done = BUSY;
        end
      end
      if ((done_cyc >= 0) && (c == done_cyc + 3)) begin
        sig_late = SIGNATURE;
        break;
      end
    end
    START = 1'b0; ABORT = 1'b0; RST = 1'b0;
  endtask

  logic [15:0] exp_sig;

  initial begin
    RST = 1'b1; START = 1'b1; ABORT = 1'b1; NUM_PAT = 8'd5;
    PAT_VALID = 1'b1; PAT_DATA = 1'b1; SO = 1'b1;
`ifdef SCAN_SEQ_MISR_EN
    exp_sig = misr_zero_ref(19);
`else
    exp_sig = 16'h0000;
`endif

    // Reset overrides START and ABORT; all outputs held at 0
    repeat (3) @(negedge CK);
    #1;
    check("reset_outputs", 32'(out_vec()), 32'd0);
    @(negedge CK);
    RST = 1'b0; START = 1'b0; ABORT = 1'b0;
    #1;
    check("idle_after_reset", 32'(out_vec()), 32'd0);

    // Single pattern, no stalls, SO tied low
    run_session(1, -100, 0, -1, -1, 1'b1, 200);
    check("p1_first_load", first_load, 1);
    check("p1_last_load", last_load, 19);
    check("p1_capture_cyc", first_cap, 20);
    check("p1_capture_cnt", n_cap, 1);
    check("p1_first_unload", first_unl, 21);
    check("p1_last_unload", last_unl, 39);
    check("p1_done_cyc", done_cyc, 40);
    check("p1_resp_cnt", n_resp, 19);
    check("p1_busy_cyc1", busy_at1, 1);
    check("p1_busy_in_fin", busy_at_done, 0);
    check("p1_data_path", n_bad, 0);
    check("p1_signature", sig_late, exp_sig);

    // Three patterns, PAT_VALID low for 5 cycles in the first SHIFT
    run_session(3, 25, 5, -1, -1, 1'b0, 300);
    check("p3_first_load", first_load, 1);
    check("p3_capture_cnt", n_cap, 3);
    check("p3_stall_cnt", n_stall, 5);
    check("p3_done_cyc", done_cyc, 85);
    check("p3_resp_cnt", n_resp, 57);
    check("p3_unload_span", last_unl - first_unl, 18);
    check("p3_data_path", n_bad, 0);

    // Zero patterns: straight to FIN
    run_session(0, -100, 0, -1, -1, 1'b0, 20);
    check("p0_done_cyc", done_cyc, 1);
    check("p0_se_cnt", n_se, 0);
    check("p0_chain_cnt", n_chain, 0);
    check("p0_busy_in_fin", busy_at_done, 0);

    // Abort during the capture of pattern 2 (cycle 40)
    run_session(3, -100, 0, 40, -1, 1'b0, 46);
    check("abort_capture_cnt", n_cap, 2);
    check("abort_idle_ctrl", 32'(vec_a[23:16]), 32'd0);
    check("abort_no_done", n_done, 0);
    check("abort_resp_cnt", n_resp, 19);

    run_session(1, -100, 0, -1, -1, 1'b0, 200);
    check("post_abort_done_cyc", done_cyc, 40);
    check("post_abort_resp_cnt", n_resp, 19);
    check("post_abort_data_path", n_bad, 0);

    // Reset together with START in the middle of SHIFT
    run_session(2, -100, 0, -1, 25, 1'b0, 29);
    check("rst_during_outputs", 32'(vec_a), 32'd0);
    check("rst_next_outputs", 32'(vec_b), 32'd0);
    check("rst_start_ignored", 32'(vec_c), 32'd0);
    check("rst_no_done", n_done, 0);

    // Session after reset still runs normally
    run_session(1, -100, 0, -1, -1, 1'b1, 200);
    check("post_rst_done_cyc", done_cyc, 40);
    check("post_rst_signature", sig_late, exp_sig);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
